// File: rtl/hub_counter_scanner_pkg.sv
// Shared types and helpers for the hub counter scanner.
// Holds the scan state encoding, width helper and counter address arithmetic.
package hub_counter_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OUT  = 2'd2,
    ST_WAIT = 2'd3
  } scan_state_e;

  // $clog2 clamped to 1 so single-entry dimensions still get a real bit
  function automatic int width_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int entry_addr(input int base, input int stride,
                                    input int port, input int index);
    return base + port * stride + index;
  endfunction

endpackage

// File: rtl/hub_counter_scanner_if.sv
// Wishbone read bus plus result stream of the hub counter scanner.
// master: scanner side; slave: hub/consumer side.
interface hub_counter_scanner_if #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int COUNTER_WIDTH = 16,
  parameter int PORT_W        = 2,
  parameter int INDEX_W       = 2
);
  logic                     wb_cyc;
  logic                     wb_stb;
  logic                     wb_we;
  logic [ADDR_WIDTH-1:0]    wb_adr;
  logic [DATA_WIDTH-1:0]    wb_dat_i;
  logic                     wb_ack;
  logic                     wb_err;

  logic                     out_valid;
  logic                     out_ready;
  logic [PORT_W-1:0]        out_port;
  logic [INDEX_W-1:0]       out_index;
  logic [COUNTER_WIDTH-1:0] out_value;
  logic                     out_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr,
    input  wb_dat_i, wb_ack, wb_err,
    output out_valid, out_port, out_index, out_value, out_err,
    input  out_ready
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr,
    output wb_dat_i, wb_ack, wb_err,
    input  out_valid, out_port, out_index, out_value, out_err,
    output out_ready
  );
endinterface

// File: rtl/hub_counter_scanner_wb_read_master.sv
// Single-read Wishbone classic engine with an access timeout.
// done is combinational in the cycle the access terminates; cyc drops at that edge.
module hub_counter_scanner_wb_read_master
  import hub_counter_scanner_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    TIMEOUT    = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADR  = '0
) (
  input  logic                  clk_125,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_adr,
  output logic                  cyc,
  output logic                  stb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] adr,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack,
  input  logic                  err,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err
);

  localparam int TMR_W = width_min1(TIMEOUT);

  logic [TMR_W-1:0] tmr_q;
  logic             expired;

  assign expired = (tmr_q == TMR_W'(TIMEOUT - 1));
  assign stb     = cyc;
  assign we      = 1'b0;
  assign done    = cyc & (ack | err | expired);
  // Without ack the access ended by err or by timeout; err also wins over ack
  assign rd_err  = err | ~ack;
  assign rd_data = dat_i;

  always_ff @(posedge clk_125) begin
    if (!rst_n) begin
      cyc   <= 1'b0;
      adr   <= RESET_ADR;
      tmr_q <= '0;
    end else if (start) begin
      cyc   <= 1'b1;
      adr   <= start_adr;
      tmr_q <= '0;
    end else if (cyc) begin
      if (done) cyc <= 1'b0;
      tmr_q <= tmr_q + 1'b1;
    end
  end

endmodule

// File: rtl/hub_counter_scanner.sv
// Periodically reads every per-port hub counter over Wishbone and streams
// {port, index, value, err} results on a valid/ready interface.
module hub_counter_scanner
  import hub_counter_scanner_pkg::*;
#(
  parameter int PORT_COUNT    = 4,
  parameter int COUNTERS      = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int PORT_STRIDE   = 16,
  parameter int BASE_ADDR     = 0,
  parameter int INTERVAL      = 125000,
  parameter int TIMEOUT       = 64
) (
  input  logic                  clk_125,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  scan_done,
  hub_counter_scanner_if.master bus
);

  localparam int PORT_W  = width_min1(PORT_COUNT);
  localparam int INDEX_W = width_min1(COUNTERS);
  localparam int WAIT_W  = width_min1(INTERVAL);

  scan_state_e              state_q, state_d;
  logic [PORT_W-1:0]        port_q, port_d;
  logic [INDEX_W-1:0]       index_q, index_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic                     out_valid_q, out_valid_d;
  logic [COUNTER_WIDTH-1:0] out_value_q, out_value_d;
  logic                     out_err_q, out_err_d;
  logic                     scan_done_q, scan_done_d;

  logic                     start;
  logic [ADDR_WIDTH-1:0]    start_adr;
  logic                     rd_done;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_err;
  logic                     last_entry;
  logic                     index_wrap;

  assign index_wrap = (index_q == INDEX_W'(COUNTERS - 1));
  assign last_entry = index_wrap && (port_q == PORT_W'(PORT_COUNT - 1));

  hub_counter_scanner_wb_read_master #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TIMEOUT    (TIMEOUT),
    .RESET_ADR  (ADDR_WIDTH'(BASE_ADDR))
  ) u_rd (
    .clk_125   (clk_125),
    .rst_n     (rst_n),
    .start     (start),
    .start_adr (start_adr),
    .cyc       (bus.wb_cyc),
    .stb       (bus.wb_stb),
    .we        (bus.wb_we),
    .adr       (bus.wb_adr),
    .dat_i     (bus.wb_dat_i),
    .ack       (bus.wb_ack),
    .err       (bus.wb_err),
    .done      (rd_done),
    .rd_data   (rd_data),
    .rd_err    (rd_err)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    index_d     = index_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    scan_done_d = 1'b0;
    start       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          port_d  = '0;
          index_d = '0;
          start   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rd_done) begin
          out_valid_d = 1'b1;
          out_value_d = rd_err ? '0 : rd_data[COUNTER_WIDTH-1:0];
          out_err_d   = rd_err;
          state_d     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready_accept(out_valid_q, bus.out_ready)) begin
          out_valid_d = 1'b0;
          if (last_entry) begin
            port_d      = '0;
            index_d     = '0;
            wait_d      = '0;
            scan_done_d = 1'b1;
            state_d     = ST_WAIT;
          end else begin
            // Next request issues straight from the accept edge
            index_d = index_wrap ? '0 : index_q + 1'b1;
            port_d  = index_wrap ? port_q + 1'b1 : port_q;
            start   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(INTERVAL - 1)) begin
          if (enable) begin
            start   = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_adr = ADDR_WIDTH'(entry_addr(BASE_ADDR, PORT_STRIDE, int'(port_d), int'(index_d)));
  end

  function automatic logic out_ready_accept(input logic vld, input logic rdy);
    return vld & rdy;
  endfunction

  always_ff @(posedge clk_125) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= '0;
      index_q     <= '0;
      wait_q      <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      index_q     <= index_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_port  = port_q;
  assign bus.out_index = index_q;
  assign bus.out_value = out_value_q;
  assign bus.out_err   = out_err_q;
  assign scan_done     = scan_done_q;

endmodule

// File: tb/tb_hub_counter_scanner.sv
// Randomized scoreboard bench: a Wishbone slave model predicts every scan entry,
// a monitor pops and compares each presented result.
module tb_hub_counter_scanner;

  localparam int PC       = 4;
  localparam int NC       = 4;
  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int CW       = 16;
  localparam int STRIDE   = 16;
  localparam int BASE     = 0;
  localparam int INTERVAL = 20;
  localparam int TIMEOUT  = 64;
  localparam int PW       = 2;
  localparam int IW       = 2;

  typedef struct {
    int p;
    int i;
    int value;
    bit err;
  } exp_t;

  logic clk_125 = 1'b0;
  logic rst_n;
  logic enable;
  logic scan_done;

  hub_counter_scanner_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW),
                           .PORT_W(PW), .INDEX_W(IW)) bus ();

  hub_counter_scanner #(
    .PORT_COUNT(PC), .COUNTERS(NC), .COUNTER_WIDTH(CW), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .PORT_STRIDE(STRIDE), .BASE_ADDR(BASE),
    .INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_125   (clk_125),
    .rst_n     (rst_n),
    .enable    (enable),
    .scan_done (scan_done),
    .bus       (bus)
  );

  always #4 clk_125 = ~clk_125;

  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;
  exp_t scb[$];
  int   scan_cnt = 0;
  int   late_until = 0;
  int   lat_lo = 0, lat_hi = 3;
  int   hang_adr = -1, both_adr = -1;
  bit   err_en = 0, stray_en = 0, rnd_ready = 0, stall_arm = 0;
  bit   stall_done = 0, hang_seen = 0, both_seen = 0;

  always @(posedge clk_125) cycle_no <= cycle_no + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycle_no);
    end
  endtask

  // Wishbone slave: returns the address as data, with random latency and faults
  initial begin : slave
    int lat_t, lat_n, dur, exp_dur, exp_p, exp_i, exp_adr;
    bit hang, both, rerr, prev;
    logic [AW-1:0] adr0;
    exp_t e;
    bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_i = '0;
    prev = 0; exp_p = 0; exp_i = 0; lat_t = 0; lat_n = 0; dur = 0; exp_dur = 0;
    hang = 0; both = 0; rerr = 0; adr0 = '0;
    forever begin
      @(posedge clk_125); #1;
      bus.wb_ack = 1'b0; bus.wb_err = 1'b0;
      if (!bus.wb_cyc && cycle_no < late_until) begin
        bus.wb_ack = 1'b1; bus.wb_dat_i = DW'($urandom);
      end
      if (!rst_n) begin
        prev = 0; exp_p = 0; exp_i = 0;
      end else begin
        chk("stb_eq_cyc", bus.wb_stb, bus.wb_cyc);
        chk("we_zero", bus.wb_we, 0);
        if (bus.wb_cyc && !prev) begin
          exp_adr = (BASE + exp_p * STRIDE + exp_i) % (1 << AW);
          chk("wb_adr", bus.wb_adr, exp_adr);
          adr0  = bus.wb_adr;
          hang  = (exp_adr == hang_adr);
          both  = (exp_adr == both_adr);
          rerr  = !hang && !both && err_en && ($urandom_range(0, 7) == 0);
          lat_t = $urandom_range(lat_lo, lat_hi);
          lat_n = 0; dur = 0;
          e.p = exp_p; e.i = exp_i;
          e.err = hang || both || rerr;
          e.value = e.err ? 0 : exp_adr;
          exp_dur = hang ? TIMEOUT : lat_t + 1;
          scb.push_back(e);
          exp_i++;
          if (exp_i == NC) begin exp_i = 0; exp_p = (exp_p + 1) % PC; end
        end
        if (bus.wb_cyc) begin
          dur++;
          chk("adr_stable", bus.wb_adr, adr0);
          if (!hang && lat_n == lat_t) begin
            bus.wb_dat_i = (both || rerr) ? DW'($urandom) : DW'(adr0);
            bus.wb_ack = !rerr;
            bus.wb_err = both || rerr;
          end
          lat_n++;
        end else if (prev) begin
          chk("cyc_len", dur, exp_dur);
          chk("resp_to_valid", bus.out_valid, 1);
          if (hang) hang_seen = 1;
          if (both) both_seen = 1;
        end else if (stray_en && $urandom_range(0, 4) == 0) begin
          bus.wb_ack = 1'b1; bus.wb_dat_i = DW'($urandom);
        end
        prev = bus.wb_cyc;
      end
    end
  end

  // Consumer: ready always, random, or a single 10-cycle stall on entry (1,2)
  initial begin : consumer
    int stall_left;
    stall_left = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk_125); #1;
      if (stall_left > 0) begin
        bus.out_ready = 1'b0; stall_left--;
      end else if (stall_arm && !stall_done && bus.out_valid &&
                   bus.out_port == 1 && bus.out_index == 2) begin
        bus.out_ready = 1'b0; stall_left = 9; stall_done = 1;
      end else begin
        bus.out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: compares presented results with the scoreboard head
  initial begin : monitor
    bit exp_done, gap_active;
    int gap;
    exp_t e;
    exp_done = 0; gap_active = 0; gap = 0;
    forever begin
      @(negedge clk_125);
      if (!rst_n) begin
        scb.delete(); exp_done = 0; gap_active = 0;
      end else begin
        chk("scan_done", scan_done, exp_done);
        if (scan_done) scan_cnt++;
        exp_done = 0;
        if (!enable) gap_active = 0;
        if (gap_active) begin
          if (!bus.wb_cyc) gap++;
          else begin chk("interval_gap", gap, INTERVAL); gap_active = 0; end
        end
        if (bus.out_valid) begin
          chk("no_cyc_while_valid", bus.wb_cyc, 0);
          if (scb.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = scb[0];
            chk("out_port", bus.out_port, e.p);
            chk("out_index", bus.out_index, e.i);
            chk("out_value", bus.out_value, e.value);
            chk("out_err", bus.out_err, e.err);
            if (bus.out_ready) begin
              void'(scb.pop_front());
              if (e.p == PC - 1 && e.i == NC - 1) begin
                exp_done = 1; gap_active = 1; gap = 0;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_scans(input int n);
    int target;
    target = scan_cnt + n;
    for (int c = 0; c < 3000 * n && scan_cnt < target; c++) @(posedge clk_125);
    chk("scan_wait", scan_cnt, target);
  endtask

  initial begin : main
    int busy, c, hi;
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk_125);
    @(negedge clk_125);
    chk("rst_cyc", bus.wb_cyc, 0);
    chk("rst_stb", bus.wb_stb, 0);
    chk("rst_adr", bus.wb_adr, BASE);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_port", bus.out_port, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_value", bus.out_value, 0);
    chk("rst_err", bus.out_err, 0);
    chk("rst_scan_done", scan_done, 0);
    @(posedge clk_125); #1 rst_n = 1'b1;

    busy = 0;
    repeat (6) begin @(negedge clk_125); busy += bus.wb_cyc; end
    chk("idle_without_enable", busy, 0);

    // Plain scans with fixed-ready consumer
    enable = 1'b1;
    wait_scans(2);

    // Stall on (1,2), timeout on 0x21, ack+err on 0x03
    stall_arm = 1; hang_adr = 8'h21; both_adr = 8'h03;
    wait_scans(1);
    chk("stall_seen", stall_done, 1);
    chk("timeout_seen", hang_seen, 1);
    chk("ack_err_seen", both_seen, 1);
    hang_adr = -1; both_adr = -1;

    // Random backpressure, random errors and stray acks
    rnd_ready = 1; err_en = 1; stray_en = 1;
    wait_scans(3);

    // Disable mid-scan at (1,0): the scan completes, then stays idle
    for (c = 0; c < 3000; c++) begin
      @(negedge clk_125);
      if (bus.out_valid && bus.out_port == 1 && bus.out_index == 0) break;
    end
    chk("found_entry_1_0", c < 3000, 1);
    enable = 1'b0;
    wait_scans(1);
    busy = 0;
    repeat (3 * INTERVAL) begin @(negedge clk_125); busy += bus.wb_cyc; end
    chk("idle_after_disable", busy, 0);
    chk("scb_empty_disable", scb.size(), 0);

    // Reset during a long bus access, late ack afterwards
    rnd_ready = 0; err_en = 0; stray_en = 0;
    lat_lo = 6; lat_hi = 6;
    enable = 1'b1;
    hi = 0;
    for (c = 0; c < 3000 && hi < 2; c++) begin
      @(posedge clk_125); #1;
      hi = bus.wb_cyc ? hi + 1 : 0;
    end
    chk("cyc_before_reset", hi, 2);
    rst_n = 1'b0;
    late_until = cycle_no + 6;
    @(posedge clk_125);
    @(negedge clk_125);
    chk("rst_mid_cyc", bus.wb_cyc, 0);
    chk("rst_mid_stb", bus.wb_stb, 0);
    chk("rst_mid_valid", bus.out_valid, 0);
    @(posedge clk_125); #1;
    lat_lo = 0; lat_hi = 3;
    rst_n = 1'b1;
    wait_scans(1);

    repeat (5) @(posedge clk_125);
    chk("scb_empty_end", scb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
